// File: rtl/alu_exec_stage.sv
// Two-stage valid/ready ALU execution stage: S1 captures A/B/OP, S2 holds Y/CARRY/ZERO.
// Also keeps a saturating count of completed output handshakes.
module alu_exec_stage #(
  parameter int unsigned W     = 7,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [1:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     Y,
  output logic             CARRY,
  output logic             ZERO,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned AMT_W = 3;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;

  logic             s1_valid_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [1:0]       op_q;

  logic             s2_valid_q;
  logic [W-1:0]     y_q;
  logic             carry_q;
  logic             zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_load;
  logic             in_fire;
  logic             out_fire;

  logic [W-1:0]     y_d;
  logic             carry_d;
  logic [W:0]       sum_c;
  logic [W:0]       diff_c;
  logic [AMT_W-1:0] amt_c;
  logic [2*W-1:0]   rot_c;

  // S1 drains whenever S2 is empty or its result is being consumed this cycle
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // ALU on the S1 contents; rotate uses a doubled word so the upper half is the result
  always_comb begin
    y_d     = '0;
    carry_d = 1'b0;
    sum_c   = {1'b0, a_q} + {1'b0, b_q};
    diff_c  = {1'b0, a_q} - {1'b0, b_q};
    amt_c   = AMT_W'(32'(b_q[AMT_W-1:0]) % W);
    rot_c   = {a_q, a_q} << amt_c;
    case (op_q)
      OP_ADD: begin
        y_d     = sum_c[W-1:0];
        carry_d = sum_c[W];
      end
      OP_SUB: begin
        y_d     = diff_c[W-1:0];
        carry_d = diff_c[W];
      end
      OP_NAND: y_d = ~(a_q & b_q);
      default: y_d = rot_c[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      a_q        <= A;
      b_q        <= B;
      op_q       <= OP;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      y_q        <= y_d;
      carry_q    <= carry_d;
      zero_q     <= (y_d == '0);
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Saturating completed-operation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign Y         = y_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: arithmetic vectors, latency, backpressure,
// streaming, mid-operation reset and counter saturation.
module tb_alu_exec_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] A;
  logic [6:0] B;
  logic [1:0] OP;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] Y;
  logic       CARRY;
  logic       ZERO;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;

  alu_exec_stage #(.W(7), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .CARRY     (CARRY),
    .ZERO      (ZERO),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated op with out_ready=1: accept, wait one edge, check the S2 result, drain
  task automatic op1(input string tag, input logic [1:0] op, input logic [6:0] a,
                     input logic [6:0] b, input logic [6:0] ey, input logic ec,
                     input logic ez);
    in_valid = 1'b1; OP = op; A = a; B = b;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"},     32'(Y),         32'(ey));
    chk({tag, "_carry"}, 32'(CARRY),     32'(ec));
    chk({tag, "_zero"},  32'(ZERO),      32'(ez));
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; OP = 2'b00;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y",         32'(Y),         32'd0);
    chk("rst_carry",     32'(CARRY),     32'd0);
    chk("rst_zero",      32'(ZERO),      32'd0);
    chk("rst_count",     32'(op_count),  32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: ADD 7F+01 with latency checks
    in_valid = 1'b1; OP = 2'b00; A = 7'h7F; B = 7'h01;
    tick();
    in_valid = 1'b0;
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_y",     32'(Y),         32'h00);
    chk("t1_carry", 32'(CARRY),     32'd1);
    chk("t1_zero",  32'(ZERO),      32'd1);
    chk("t1_count_before", 32'(op_count), 32'd0);
    tick();
    chk("t1_count", 32'(op_count), 32'd1);
    chk("t1_drained", 32'(out_valid), 32'd0);

    // Tests 2-3: SUB, NAND, ROL
    op1("sub_borrow", 2'b01, 7'h05, 7'h07, 7'h7E, 1'b1, 1'b0);
    op1("sub_zero",   2'b01, 7'h07, 7'h07, 7'h00, 1'b0, 1'b1);
    op1("nand",       2'b10, 7'h55, 7'h0F, 7'h7A, 1'b0, 1'b0);
    op1("rol2",       2'b11, 7'b1000001, 7'h02, 7'h06, 1'b0, 1'b0);
    op1("rol7",       2'b11, 7'b1000001, 7'h07, 7'h41, 1'b0, 1'b0);
    op1("rol3_hib",   2'b11, 7'b1000001, 7'h7B, 7'h0C, 1'b0, 1'b0);
    op1("add_nc",     2'b00, 7'h40, 7'h3F, 7'h7F, 1'b0, 1'b0);
    chk("count_after_t3", 32'(op_count), 32'd8);

    // Test 4: backpressure with 1+1, 2+2, 3+3, 4+4
    OP = 2'b00; in_valid = 1'b1; A = 7'd1; B = 7'd1; out_ready = 1'b1;
    tick();
    A = 7'd2; B = 7'd2; out_ready = 1'b0;
    tick();
    A = 7'd3; B = 7'd3;
    #1;
    chk("bp_in_ready_low", 32'(in_ready),  32'd0);
    chk("bp_valid",        32'(out_valid), 32'd1);
    chk("bp_y_hold0",      32'(Y),         32'h02);
    tick();
    chk("bp_y_hold1",      32'(Y),         32'h02);
    chk("bp_in_ready_low1", 32'(in_ready), 32'd0);
    tick();
    chk("bp_y_hold2",      32'(Y),         32'h02);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
    tick();
    chk("bp_y4", 32'(Y), 32'h04);
    A = 7'd4; B = 7'd4;
    tick();
    chk("bp_y6", 32'(Y), 32'h06);
    in_valid = 1'b0;
    tick();
    chk("bp_y8",     32'(Y),         32'h08);
    chk("bp_valid8", 32'(out_valid), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_count",   32'(op_count),  32'd12);

    // Test 5: 10-op continuous stream, Y = A since B = 0
    B = 7'd0; OP = 2'b00;
    for (int t = 0; t < 14; t++) begin
      if (t < 10) begin
        in_valid = 1'b1; A = 7'(t + 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk($sformatf("stream_valid_%0d", t), 32'(out_valid),
          (t >= 1 && t <= 10) ? 32'd1 : 32'd0);
      if (t >= 1 && t <= 10) chk($sformatf("stream_y_%0d", t), 32'(Y), 32'(t));
    end
    chk("stream_count", 32'(op_count), 32'd22);

    // Test 6a: reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; A = 7'h11; B = 7'h22;
    tick(); tick();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 32'(in_ready),  32'd0);
    chk("full_valid",    32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid",    32'(out_valid), 32'd0);
    chk("mrst_count",    32'(op_count),  32'd0);
    chk("mrst_in_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("mrst_no_stale_%0d", t), 32'(out_valid), 32'd0);
    end
    chk("mrst_count_hold", 32'(op_count), 32'd0);

    // Test 6b: saturate op_count at 255
    in_valid = 1'b1; OP = 2'b10; A = 7'h01; B = 7'h01;
    for (int t = 0; t < 255; t++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat_255", 32'(op_count), 32'd255);
    op1("sat_extra", 2'b00, 7'h01, 7'h02, 7'h03, 1'b0, 1'b0);
    chk("sat_hold", 32'(op_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
